// File: rtl/alu1_driver.sv
// alu1_driver: initiator for an Alu1 cmd/in1/in2/out port.
// Takes one ALU op at a time from a valid/ready request port. It registers the
// operands onto the Alu1 inputs and waits ALU_LAT cycles for the result. It then
// offers the captured result on a valid/ready response port. Commands at or above
// NR_COMMANDS are answered at once with rsp_err set and a zero result.
module alu1_driver #(
  parameter int WIDTH       = 64,
  parameter int CMD_WIDTH   = 4,   // Alu1 command field width
  parameter int NR_COMMANDS = 10,  // Alu1 legal command count
  parameter int ALU_LAT     = 0,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [CMD_WIDTH-1:0] req_cmd,
  input  logic [WIDTH-1:0]     req_in1,
  input  logic [WIDTH-1:0]     req_in2,
  output logic [CMD_WIDTH-1:0] alu_cmd,
  output logic [WIDTH-1:0]     alu_in1,
  output logic [WIDTH-1:0]     alu_in2,
  input  logic [WIDTH-1:0]     alu_out,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [WIDTH-1:0]     rsp_data,
  output logic                 rsp_err,
  output logic [CNT_WIDTH-1:0] op_count
);

  // The latency counter must be able to hold ALU_LAT. It is at least one bit wide.
  localparam int LAT_W = (ALU_LAT > 0) ? $clog2(ALU_LAT + 1) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t               state_r, state_s;
  logic [LAT_W-1:0]     lat_cnt_r, lat_cnt_s;
  logic [CMD_WIDTH-1:0] alu_cmd_r, alu_cmd_s;
  logic [WIDTH-1:0]     alu_in1_r, alu_in1_s;
  logic [WIDTH-1:0]     alu_in2_r, alu_in2_s;
  logic [WIDTH-1:0]     rsp_data_r, rsp_data_s;
  logic                 rsp_err_r, rsp_err_s;
  logic [CNT_WIDTH-1:0] op_count_r, op_count_s;
  logic                 req_ready_r;
  logic                 rsp_valid_r;
  logic                 accept_s;
  logic                 rsp_hs_s;

  // A command is legal when it is below NR_COMMANDS. The compare is done at 32 bits
  // so that a parameter larger than the field range stays correct.
  function automatic logic cmd_is_legal(input logic [CMD_WIDTH-1:0] cmd);
    logic [31:0] cmd_ext;
    cmd_ext = 32'(cmd);
    return (cmd_ext < 32'(NR_COMMANDS));
  endfunction

  assign accept_s = req_valid & req_ready_r;
  assign rsp_hs_s = rsp_valid_r & rsp_ready;

  // Next-state logic and next values for all datapath registers.
  always_comb begin
    state_s    = state_r;
    lat_cnt_s  = lat_cnt_r;
    alu_cmd_s  = alu_cmd_r;
    alu_in1_s  = alu_in1_r;
    alu_in2_s  = alu_in2_r;
    rsp_data_s = rsp_data_r;
    rsp_err_s  = rsp_err_r;
    op_count_s = op_count_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          // The operands always reach the ALU, even for an illegal command.
          alu_cmd_s = req_cmd;
          alu_in1_s = req_in1;
          alu_in2_s = req_in2;
          if (cmd_is_legal(req_cmd)) begin
            state_s   = ST_WAIT;
            lat_cnt_s = LAT_W'(ALU_LAT);
          end else begin
            state_s    = ST_RESP;
            rsp_data_s = '0;
            rsp_err_s  = 1'b1;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (lat_cnt_r != '0) begin
          lat_cnt_s = lat_cnt_r - LAT_W'(1);
        end else begin
          // The ALU output has settled for this op. Capture it now.
          rsp_data_s = alu_out;
          rsp_err_s  = 1'b0;
          state_s    = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_hs_s) begin
          op_count_s = op_count_r + CNT_WIDTH'(1);
          state_s    = ST_IDLE;
        end else begin
          state_s = ST_RESP;
        end
      end
      default: begin
        state_s   = ST_IDLE;
        lat_cnt_s = '0;
      end
    endcase
  end

  // State and datapath registers. On reset, any op that is in flight is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      lat_cnt_r  <= '0;
      alu_cmd_r  <= '0;
      alu_in1_r  <= '0;
      alu_in2_r  <= '0;
      rsp_data_r <= '0;
      rsp_err_r  <= 1'b0;
      op_count_r <= '0;
    end else begin
      state_r    <= state_s;
      lat_cnt_r  <= lat_cnt_s;
      alu_cmd_r  <= alu_cmd_s;
      alu_in1_r  <= alu_in1_s;
      alu_in2_r  <= alu_in2_s;
      rsp_data_r <= rsp_data_s;
      rsp_err_r  <= rsp_err_s;
      op_count_r <= op_count_s;
    end
  end

  // Registered handshake outputs. They are decoded from the next state, so they track
  // the state with no lag. req_ready first rises on the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_ready_r <= 1'b0;
      rsp_valid_r <= 1'b0;
    end else begin
      req_ready_r <= (state_s == ST_IDLE);
      rsp_valid_r <= (state_s == ST_RESP);
    end
  end

  assign req_ready = req_ready_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_data  = rsp_data_r;
  assign rsp_err   = rsp_err_r;
  assign op_count  = op_count_r;
  assign alu_cmd   = alu_cmd_r;
  assign alu_in1   = alu_in1_r;
  assign alu_in2   = alu_in2_r;

endmodule

// File: tb/tb_alu1_driver.sv
// Directed bench for alu1_driver.
// Instance 0 uses ALU_LAT=0 with a 32-bit counter. Instance 1 uses ALU_LAT=3 with a
// 3-bit counter, so that a counter wrap is reachable. The stub ALU returns in1+in2.
module tb_alu1_driver;

  logic clk;
  logic rst_n;
  logic [1:0]        req_valid, req_ready, rsp_valid, rsp_ready, rsp_err;
  logic [1:0][3:0]   req_cmd, alu_cmd;
  logic [1:0][63:0]  req_in1, req_in2, alu_in1, alu_in2, alu_out, rsp_data;
  logic [1:0][31:0]  opc;
  logic [2:0]        opc_b;
  logic [63:0]       pipe [3];
  logic [31:0]       exp_cnt [2];
  int                lat_of [2];
  int                checks;
  int                failures;

  alu1_driver #(.WIDTH(64), .CMD_WIDTH(4), .NR_COMMANDS(10), .ALU_LAT(0), .CNT_WIDTH(32)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_cmd(req_cmd[0]),
    .req_in1(req_in1[0]), .req_in2(req_in2[0]),
    .alu_cmd(alu_cmd[0]), .alu_in1(alu_in1[0]), .alu_in2(alu_in2[0]), .alu_out(alu_out[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_data(rsp_data[0]),
    .rsp_err(rsp_err[0]), .op_count(opc[0])
  );

  alu1_driver #(.WIDTH(64), .CMD_WIDTH(4), .NR_COMMANDS(10), .ALU_LAT(3), .CNT_WIDTH(3)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_cmd(req_cmd[1]),
    .req_in1(req_in1[1]), .req_in2(req_in2[1]),
    .alu_cmd(alu_cmd[1]), .alu_in1(alu_in1[1]), .alu_in2(alu_in2[1]), .alu_out(alu_out[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_data(rsp_data[1]),
    .rsp_err(rsp_err[1]), .op_count(opc_b)
  );

  assign opc[1] = {29'd0, opc_b};

  // Stub ALUs: one combinational, one behind a three-stage register pipe.
  assign alu_out[0] = alu_in1[0] + alu_in2[0];
  always @(posedge clk) begin
    pipe[0] <= alu_in1[1] + alu_in2[1];
    pipe[1] <= pipe[0];
    pipe[2] <= pipe[1];
  end
  assign alu_out[1] = pipe[2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic bump(input int d);
    exp_cnt[d] = (d == 1) ? ((exp_cnt[d] + 32'd1) & 32'd7) : (exp_cnt[d] + 32'd1);
  endtask

  // Sends one op with rsp_ready held high. It returns the number of cycles from the
  // accept edge to rsp_valid (-1 on timeout), plus the response that was seen.
  task automatic send_op(input int d, input logic [3:0] cmd, input logic [63:0] a, input logic [63:0] b,
                         output int lat, output logic [63:0] data, output logic err);
    int n;
    req_cmd[d] = cmd; req_in1[d] = a; req_in2[d] = b;
    req_valid[d] = 1'b1; rsp_ready[d] = 1'b1;
    n = 0;
    while (req_ready[d] !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
    n = 0;
    while (rsp_valid[d] !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    lat  = (rsp_valid[d] === 1'b1) ? n : -1;
    data = rsp_data[d];
    err  = rsp_err[d];
    @(posedge clk); #1;
    if (lat >= 0) bump(d);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (rsp_valid[d] !== 1'b0 || rsp_data[d] !== 64'd0 || rsp_err[d] !== 1'b0) begin
        failures++; $display("FAIL reset_rsp[%0d]: valid=%b data=%h err=%b expected 0/0/0", d, rsp_valid[d], rsp_data[d], rsp_err[d]);
      end
      checks++;
      if (alu_cmd[d] !== 4'd0 || alu_in1[d] !== 64'd0 || alu_in2[d] !== 64'd0 || opc[d] !== 32'd0) begin
        failures++; $display("FAIL reset_alu[%0d]: cmd=%h in1=%h in2=%h cnt=%0d expected all 0", d, alu_cmd[d], alu_in1[d], alu_in2[d], opc[d]);
      end
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (req_ready[d] !== 1'b1) begin
        failures++; $display("FAIL reset_ready[%0d]: got %b expected 1", d, req_ready[d]);
      end
      exp_cnt[d] = 32'd0;
    end
  endtask

  task automatic test_basic(input int d);
    int lat; logic [63:0] data; logic err;
    send_op(d, 4'd0, 64'd5, 64'd7, lat, data, err);
    checks++;
    if (lat !== lat_of[d] + 1) begin failures++; $display("FAIL basic_lat[%0d]: got %0d expected %0d", d, lat, lat_of[d] + 1); end
    checks++;
    if (data !== 64'd12 || err !== 1'b0) begin failures++; $display("FAIL basic_data[%0d]: got %h err=%b expected 12 err=0", d, data, err); end
    checks++;
    if (opc[d] !== exp_cnt[d] || req_ready[d] !== 1'b1 || rsp_valid[d] !== 1'b0) begin
      failures++; $display("FAIL basic_done[%0d]: cnt=%0d ready=%b valid=%b expected cnt=%0d ready=1 valid=0", d, opc[d], req_ready[d], rsp_valid[d], exp_cnt[d]);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (alu_cmd[d] !== 4'd0 || alu_in1[d] !== 64'd5 || alu_in2[d] !== 64'd7) begin
      failures++; $display("FAIL basic_hold[%0d]: cmd=%h in1=%h in2=%h expected 0/5/7", d, alu_cmd[d], alu_in1[d], alu_in2[d]);
    end
  endtask

  task automatic test_wrap(input int d);
    int lat; logic [63:0] data; logic err;
    send_op(d, 4'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, lat, data, err);
    checks++;
    if (lat !== lat_of[d] + 1 || data !== 64'd0 || err !== 1'b0) begin
      failures++; $display("FAIL wrap_sum[%0d]: lat=%0d data=%h err=%b expected lat=%0d data=0 err=0", d, lat, data, err, lat_of[d] + 1);
    end
    send_op(d, 4'd3, 64'h1234_5678_9ABC_DEF0, 64'h0F0F_0F0F_0F0F_0F0F, lat, data, err);
    checks++;
    if (data !== 64'h2143_6587_A9CB_EDFF || err !== 1'b0) begin
      failures++; $display("FAIL pattern_sum[%0d]: got %h err=%b expected 21436587a9cbedff err=0", d, data, err);
    end
    send_op(d, 4'd9, 64'd100, 64'd200, lat, data, err);
    checks++;
    if (lat !== lat_of[d] + 1 || data !== 64'd300 || err !== 1'b0) begin
      failures++; $display("FAIL last_legal[%0d]: lat=%0d data=%0d err=%b expected lat=%0d data=300 err=0", d, lat, data, err, lat_of[d] + 1);
    end
    checks++;
    if (opc[d] !== exp_cnt[d]) begin failures++; $display("FAIL wrap_cnt[%0d]: got %0d expected %0d", d, opc[d], exp_cnt[d]); end
  endtask

  task automatic test_illegal(input int d);
    int lat; logic [63:0] data; logic err;
    send_op(d, 4'd10, 64'd11, 64'd22, lat, data, err);
    checks++;
    if (lat !== 0 || err !== 1'b1 || data !== 64'd0) begin
      failures++; $display("FAIL illegal_nr[%0d]: lat=%0d err=%b data=%h expected lat=0 err=1 data=0", d, lat, err, data);
    end
    checks++;
    if (opc[d] !== exp_cnt[d] || alu_cmd[d] !== 4'd10 || alu_in1[d] !== 64'd11) begin
      failures++; $display("FAIL illegal_cnt[%0d]: cnt=%0d cmd=%h in1=%h expected cnt=%0d cmd=a in1=b", d, opc[d], alu_cmd[d], alu_in1[d], exp_cnt[d]);
    end
    send_op(d, 4'd15, 64'd1, 64'd1, lat, data, err);
    checks++;
    if (lat !== 0 || err !== 1'b1 || data !== 64'd0 || opc[d] !== exp_cnt[d]) begin
      failures++; $display("FAIL illegal_max[%0d]: lat=%0d err=%b data=%h cnt=%0d expected 0/1/0/%0d", d, lat, err, data, opc[d], exp_cnt[d]);
    end
  endtask

  task automatic test_back_to_back(input int d);
    int n; logic stable_ok;
    rsp_ready[d] = 1'b0;
    req_cmd[d] = 4'd1; req_in1[d] = 64'd3; req_in2[d] = 64'd4; req_valid[d] = 1'b1;
    n = 0;
    while (req_ready[d] !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    req_cmd[d] = 4'd2; req_in1[d] = 64'd10; req_in2[d] = 64'd20;
    n = 0;
    while (rsp_valid[d] !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    checks++;
    if (rsp_valid[d] !== 1'b1 || rsp_data[d] !== 64'd7) begin
      failures++; $display("FAIL bp_first[%0d]: valid=%b data=%h expected 1/7", d, rsp_valid[d], rsp_data[d]);
    end
    stable_ok = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      if (rsp_valid[d] !== 1'b1 || rsp_data[d] !== 64'd7 || rsp_err[d] !== 1'b0 || req_ready[d] !== 1'b0) stable_ok = 1'b0;
    end
    checks++;
    if (stable_ok !== 1'b1) begin failures++; $display("FAIL bp_stable[%0d]: got %b expected 1", d, stable_ok); end
    checks++;
    if (alu_in1[d] !== 64'd3 || alu_cmd[d] !== 4'd1) begin
      failures++; $display("FAIL bp_no_accept[%0d]: in1=%h cmd=%h expected 3/1", d, alu_in1[d], alu_cmd[d]);
    end
    rsp_ready[d] = 1'b1;
    @(posedge clk); #1;
    bump(d);
    checks++;
    if (opc[d] !== exp_cnt[d] || req_ready[d] !== 1'b1) begin
      failures++; $display("FAIL bp_hs[%0d]: cnt=%0d ready=%b expected %0d/1", d, opc[d], req_ready[d], exp_cnt[d]);
    end
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
    checks++;
    if (alu_in1[d] !== 64'd10 || alu_cmd[d] !== 4'd2) begin
      failures++; $display("FAIL bp_second_accept[%0d]: in1=%h cmd=%h expected a/2", d, alu_in1[d], alu_cmd[d]);
    end
    n = 0;
    while (rsp_valid[d] !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    checks++;
    if (rsp_valid[d] !== 1'b1 || rsp_data[d] !== 64'd30) begin
      failures++; $display("FAIL bp_second[%0d]: valid=%b data=%h expected 1/1e", d, rsp_valid[d], rsp_data[d]);
    end
    @(posedge clk); #1;
    bump(d);
  endtask

  task automatic test_reset_mid;
    int n; int lat; logic [63:0] data; logic err; logic quiet;
    req_cmd[1] = 4'd0; req_in1[1] = 64'd1; req_in2[1] = 64'd2; req_valid[1] = 1'b1; rsp_ready[1] = 1'b1;
    n = 0;
    while (req_ready[1] !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (rsp_valid[1] !== 1'b0 || opc[1] !== 32'd0 || alu_in1[1] !== 64'd0 || alu_in2[1] !== 64'd0 || alu_cmd[1] !== 4'd0) begin
      failures++; $display("FAIL midreset_clear: valid=%b cnt=%0d in1=%h in2=%h cmd=%h expected all 0", rsp_valid[1], opc[1], alu_in1[1], alu_in2[1], alu_cmd[1]);
    end
    exp_cnt[0] = 32'd0; exp_cnt[1] = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    quiet = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      if (rsp_valid[1] !== 1'b0) quiet = 1'b0;
    end
    checks++;
    if (quiet !== 1'b1 || opc[1] !== 32'd0) begin failures++; $display("FAIL midreset_quiet: quiet=%b cnt=%0d expected 1/0", quiet, opc[1]); end
    send_op(1, 4'd0, 64'd20, 64'd22, lat, data, err);
    checks++;
    if (lat !== 4 || data !== 64'd42 || err !== 1'b0 || opc[1] !== 32'd1) begin
      failures++; $display("FAIL midreset_after: lat=%0d data=%0d err=%b cnt=%0d expected 4/42/0/1", lat, data, err, opc[1]);
    end
  endtask

  task automatic test_cnt_wrap;
    int lat; logic [63:0] data; logic err;
    for (int i = 0; i < 10 && exp_cnt[1] != 32'd7; i++) send_op(1, 4'd2, 64'(i), 64'd1, lat, data, err);
    checks++;
    if (opc[1] !== 32'd7) begin failures++; $display("FAIL cnt_max: got %0d expected 7", opc[1]); end
    send_op(1, 4'd4, 64'd8, 64'd9, lat, data, err);
    checks++;
    if (opc[1] !== 32'd0 || data !== 64'd17) begin failures++; $display("FAIL cnt_wrap: cnt=%0d data=%0d expected 0/17", opc[1], data); end
  endtask

  initial begin
    checks = 0; failures = 0;
    lat_of[0] = 0; lat_of[1] = 3;
    exp_cnt[0] = 32'd0; exp_cnt[1] = 32'd0;
    req_valid = '0; rsp_ready = '0; req_cmd = '0; req_in1 = '0; req_in2 = '0;
    test_reset();
    for (int d = 0; d < 2; d++) begin
      test_basic(d);
      test_wrap(d);
      test_illegal(d);
      test_back_to_back(d);
    end
    test_reset_mid();
    test_cnt_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
